// File: rtl/hdr_fifo_drain_ctrl.sv
// Header FIFO drain sequencer: pops one FWFT entry into a shadow register and
// serializes it LSB-first as DATA_W-bit AXI-Stream beats with TLAST/TKEEP.
module hdr_fifo_drain_ctrl #(
    parameter int unsigned ENTRY_W = 592,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [ENTRY_W-1:0]    fifo_rdata,
    output logic                  fifo_pop,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [CNT_W-1:0]      pkt_count
);

    localparam int unsigned BEATS      = (ENTRY_W + DATA_W - 1) / DATA_W;
    localparam int unsigned PAD_W      = BEATS * DATA_W;
    localparam int unsigned KEEP_W     = DATA_W / 8;
    localparam int unsigned LAST_BYTES = (ENTRY_W - (BEATS - 1) * DATA_W) / 8;
    localparam int unsigned BCNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BCNT_W-1:0] LAST_IDX  = BCNT_W'(BEATS - 1);
    localparam logic [KEEP_W-1:0] FULL_KEEP = {KEEP_W{1'b1}};
    localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BCNT_W-1:0]   r_beat_cnt;
    logic [BCNT_W-1:0]   w_beat_nxt;
    logic [CNT_W-1:0]    r_pkt_count;
    logic [CNT_W-1:0]    w_pkt_nxt;
    logic [PAD_W-1:0]    r_shadow;
    logic                w_send;
    logic                w_is_last;
    logic                w_accept;
    logic                w_last_accept;
    logic                w_load;
    logic [DATA_W-1:0]   w_beat_words [BEATS];

    // Padding above ENTRY_W is zero, so the final beat's unused bits read as 0.
    for (genvar k = 0; k < BEATS; k++) begin : g_words
        assign w_beat_words[k] = r_shadow[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_shadow    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_pkt_count <= w_pkt_nxt;
            if (w_load) begin
                r_shadow <= PAD_W'(fifo_rdata);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat_cnt;
        w_pkt_nxt     = r_pkt_count;
        w_send        = (r_state == ST_SEND);
        w_is_last     = (r_beat_cnt == LAST_IDX);
        w_accept      = w_send && m_axis_tready;
        w_last_accept = w_accept && w_is_last;
        // A new entry is taken when idle or exactly on the final handshake.
        w_load        = !rst && en && !fifo_empty && (!w_send || w_last_accept);

        fifo_pop      = w_load;
        m_axis_tvalid = w_send;
        m_axis_tlast  = w_send && w_is_last;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        busy          = w_send;
        pkt_count     = r_pkt_count;

        if (w_send) begin
            m_axis_tkeep = w_is_last ? LAST_KEEP : FULL_KEEP;
            m_axis_tdata = w_beat_words[r_beat_cnt];
        end

        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_SEND;
                    w_beat_nxt  = '0;
                end
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (!w_is_last) begin
                        w_beat_nxt = r_beat_cnt + BCNT_W'(1);
                    end else begin
                        w_pkt_nxt  = r_pkt_count + CNT_W'(1);
                        w_beat_nxt = '0;
                        if (!w_load) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hdr_fifo_drain_ctrl.sv
// Randomized/directed bench for hdr_fifo_drain_ctrl against an entry-level
// model: a FIFO queue, the entry in flight and its remaining beat count.
module tb_hdr_fifo_drain_ctrl;

    localparam int unsigned ENTRY_W = 592;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BEATS   = 10;
    localparam int unsigned KEEP_W  = DATA_W / 8;

    logic                clk;
    logic                rst;
    logic                en;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fifo_pop;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [KEEP_W-1:0]   m_axis_tkeep;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic                busy;
    logic [CNT_W-1:0]    pkt_count;

    hdr_fifo_drain_ctrl #(
        .ENTRY_W (ENTRY_W),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_pop      (fifo_pop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: queued entries, entry in flight, beats still to send, count.
    logic [ENTRY_W-1:0] fq [$];
    logic [ENTRY_W-1:0] m_cur;
    int                 m_rem;
    int                 m_pkt;
    int                 checks;
    int                 failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [ENTRY_W-1:0] e, input int k);
        logic [BEATS*DATA_W-1:0] p;
        p = '0;
        p[ENTRY_W-1:0] = e;
        return 64'(p >> (DATA_W * k));
    endfunction

    function automatic logic [7:0] exp_keep(input int k);
        int nb;
        nb = int'(ENTRY_W / 8) - 8 * k;
        if (nb > 8) nb = 8;
        return 8'((1 << nb) - 1);
    endfunction

    function automatic logic [ENTRY_W-1:0] rand_entry();
        logic [607:0] t;
        t = '0;
        for (int i = 0; i < 19; i++) t = {t[575:0], 32'($urandom)};
        return t[ENTRY_W-1:0];
    endfunction

    function automatic logic [ENTRY_W-1:0] count_entry();
        logic [ENTRY_W-1:0] p;
        p = '0;
        for (int i = 0; i < int'(ENTRY_W / 8); i++) p = {8'(i), p[ENTRY_W-1:8]};
        return p;
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? rand_entry() : fq[0];
    endtask

    task automatic push(input logic [ENTRY_W-1:0] e);
        fq.push_back(e);
        drive_fifo();
    endtask

    // One clock: compare outputs at the falling edge, advance model at the rising edge.
    task automatic cycle();
        logic acc;
        logic exp_pop;
        int   idx;
        @(negedge clk);
        acc     = (m_rem > 0) && m_axis_tready;
        exp_pop = !rst && en && (fq.size() > 0) && ((m_rem == 0) || (acc && m_rem == 1));
        chk("fifo_pop",  64'(fifo_pop),      64'(exp_pop));
        chk("tvalid",    64'(m_axis_tvalid), 64'(m_rem > 0));
        chk("busy",      64'(busy),          64'(m_rem > 0));
        chk("pkt_count", 64'(pkt_count),     64'(m_pkt));
        if (m_rem > 0) begin
            idx = BEATS - m_rem;
            chk("tdata", m_axis_tdata,        exp_word(m_cur, idx));
            chk("tkeep", 64'(m_axis_tkeep),   64'(exp_keep(idx)));
            chk("tlast", 64'(m_axis_tlast),   64'(idx == BEATS - 1));
        end
        @(posedge clk);
        if (rst) begin
            fq.delete();
            m_rem = 0;
            m_pkt = 0;
        end else begin
            if (acc) begin
                m_rem--;
                if (m_rem == 0) m_pkt = (m_pkt + 1) % (1 << CNT_W);
            end
            if (exp_pop) begin
                m_cur = fq.pop_front();
                m_rem = BEATS;
            end
        end
        #1;
        drive_fifo();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_rem(input int target);
        int n;
        n = 0;
        while (m_rem != target && n < 200) begin
            cycle();
            n++;
        end
        chk("wait_bound", 64'(n < 200), 64'(1));
    endtask

    task automatic drain(input bit rnd_ready);
        int n;
        n = 0;
        while ((fq.size() > 0 || m_rem > 0) && n < 2000) begin
            if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        chk("drain_bound", 64'(n < 2000), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        m_rem = 0; m_pkt = 0; m_cur = '0;
        rst = 1'b1; en = 1'b0; m_axis_tready = 1'b0;
        drive_fifo();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tdata",  m_axis_tdata,        64'(0));
        chk("rst_tkeep",  64'(m_axis_tkeep),   64'(0));
        chk("rst_tlast",  64'(m_axis_tlast),   64'(0));
        chk("rst_tvalid", 64'(m_axis_tvalid),  64'(0));
        @(posedge clk);
        #1;
        do_reset();

        // Single counting-pattern entry, tready held high
        en = 1'b1; m_axis_tready = 1'b1;
        push(count_entry());
        run(14);
        chk("single_pkt",  64'(pkt_count), 64'(1));
        chk("single_busy", 64'(busy),      64'(0));

        // Same entry with tready stalls 1,0,0,1
        push(count_entry());
        for (int i = 0; i < 44; i++) begin
            m_axis_tready = (i % 4 == 0) || (i % 4 == 3);
            cycle();
        end
        chk("stall_pkt", 64'(pkt_count), 64'(2));

        // Two queued entries back-to-back
        m_axis_tready = 1'b1;
        push(rand_entry());
        push(rand_entry());
        run(23);
        chk("b2b_pkt", 64'(pkt_count), 64'(4));

        // en dropped at beat 4 with two entries queued
        push(rand_entry());
        push(rand_entry());
        wait_rem(6);
        en = 1'b0;
        run(20);
        chk("en_hold_empty", 64'(fifo_empty), 64'(0));
        chk("en_hold_busy",  64'(busy),       64'(0));
        en = 1'b1;
        run(14);

        // Reset at beat 5, then a fresh entry drains from beat 0
        push(rand_entry());
        wait_rem(5);
        do_reset();
        cycle();
        chk("post_rst_pkt", 64'(pkt_count), 64'(0));
        push(rand_entry());
        run(14);

        // Counter wrap: 17 entries from zero
        do_reset();
        for (int i = 0; i < 17; i++) push(rand_entry());
        drain(1'b1);
        chk("wrap_pkt", 64'(pkt_count), 64'(1));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            en            = ($urandom_range(0, 9) != 0);
            m_axis_tready = ($urandom_range(0, 2) != 0);
            if (fq.size() < 4 && $urandom_range(0, 7) == 0) push(rand_entry());
            cycle();
        end
        en = 1'b1;
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
